// File: rtl/backprop_error_collector.sv
// Lane-wise saturating accumulator of downstream backprop-change vectors.
// After NUM_DOWN accepted contributions the summed errors are presented as one batch.
module backprop_error_collector #(
  parameter int LANES     = 32,
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 64,
  parameter int NUM_DOWN  = 4,
  localparam int CNT_W    = $clog2(NUM_DOWN + 1)
) (
  input  logic                                be_clock,
  input  logic                                be_reset_n,
  input  logic                                be_clear,
  input  logic                                be_in_valid,
  output logic                                be_in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]         be_in_change,
  input  logic [LANES-1:0]                    be_in_mask,
  output logic                                be_out_valid,
  input  logic                                be_out_ready,
  output logic [LANES-1:0][ACC_WIDTH-1:0]     be_out_backprop,
  output logic                                be_out_overflow,
  output logic [CNT_W-1:0]                    be_count
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [LANES-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
  logic                            ovf_q, ovf_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [LANES-1:0][ACC_WIDTH:0]   sat_s;

  // Result is {clamped, value}; the sum is formed one bit wider so overflow is visible.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0]     chg);
    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] res;
    sum = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH + 1 - WIDTH){chg[WIDTH-1]}}, chg};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      res = {1'b1, sum[ACC_WIDTH], {(ACC_WIDTH - 1){~sum[ACC_WIDTH]}}};
    end else begin
      res = {1'b0, sum[ACC_WIDTH-1:0]};
    end
    return res;
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_sat
    assign sat_s[k] = sat_add(acc_q[k], be_in_change[k]);
  end

  // Next-state: clear has priority over accept and handoff.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (be_clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (be_in_valid) begin
            for (int k = 0; k < LANES; k++) begin
              if (be_in_mask[k]) begin
                acc_d[k] = sat_s[k][ACC_WIDTH-1:0];
                ovf_d    = ovf_d | sat_s[k][ACC_WIDTH];
              end else begin
                acc_d[k] = acc_q[k];
              end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_DOWN - 1)) begin
              state_d = ST_FULL;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_FULL: begin
          if (be_out_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge be_clock or negedge be_reset_n) begin
    if (!be_reset_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is gated by reset so it drops immediately while reset is held.
  assign be_in_ready     = be_reset_n & (state_q == ST_ACCUM);
  assign be_out_valid    = (state_q == ST_FULL);
  assign be_out_backprop = acc_q;
  assign be_out_overflow = ovf_q;
  assign be_count        = cnt_q;

endmodule

// File: tb/tb_backprop_error_collector.sv
// Directed bench: table-driven vectors on the default instance, hand sequences for
// async reset and a narrow-accumulator (34-bit, 8-beat) saturation instance.
module tb_backprop_error_collector;

  logic clk;
  logic rst_n;

  // Default-parameter instance
  logic                    d_clear, d_valid, d_ready, d_oready, d_ov, d_ovf;
  logic [31:0][31:0]       d_chg;
  logic [31:0]             d_mask;
  logic [31:0][63:0]       d_bp;
  logic [2:0]              d_cnt;

  // ACC_WIDTH=34, NUM_DOWN=8 instance
  logic                    w_clear, w_valid, w_ready, w_oready, w_ov, w_ovf;
  logic [31:0][31:0]       w_chg;
  logic [31:0]             w_mask;
  logic [31:0][33:0]       w_bp;
  logic [3:0]              w_cnt;

  int n_chk;
  int n_fail;

  backprop_error_collector dut (
    .be_clock(clk), .be_reset_n(rst_n), .be_clear(d_clear),
    .be_in_valid(d_valid), .be_in_ready(d_ready), .be_in_change(d_chg),
    .be_in_mask(d_mask), .be_out_valid(d_ov), .be_out_ready(d_oready),
    .be_out_backprop(d_bp), .be_out_overflow(d_ovf), .be_count(d_cnt)
  );

  backprop_error_collector #(.ACC_WIDTH(34), .NUM_DOWN(8)) dut_w (
    .be_clock(clk), .be_reset_n(rst_n), .be_clear(w_clear),
    .be_in_valid(w_valid), .be_in_ready(w_ready), .be_in_change(w_chg),
    .be_in_mask(w_mask), .be_out_valid(w_ov), .be_out_ready(w_oready),
    .be_out_backprop(w_bp), .be_out_overflow(w_ovf), .be_count(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, clear, oready, ramp;
    logic [31:0] mask, a, b;
    logic        e_ov, e_ir, e_ovf;
    logic [2:0]  e_cnt;
    logic [63:0] e_l0, e_l1, e_l31;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic c, input logic o, input logic r,
                     input logic [31:0] m, input logic [31:0] a, input logic [31:0] b,
                     input logic eov, input logic eir, input logic [2:0] ecnt,
                     input logic eovf, input logic [63:0] l0, input logic [63:0] l1,
                     input logic [63:0] l31);
    vec_t x;
    x.valid = v; x.clear = c; x.oready = o; x.ramp = r;
    x.mask = m; x.a = a; x.b = b;
    x.e_ov = eov; x.e_ir = eir; x.e_cnt = ecnt; x.e_ovf = eovf;
    x.e_l0 = l0; x.e_l1 = l1; x.e_l31 = l31;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wstep(input logic v, input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    w_valid  = v;
    w_oready = o;
    for (int k = 0; k < 32; k++) w_chg[k] = (k == 0) ? a : b;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    d_clear = 1'b0; d_valid = 1'b0; d_oready = 1'b0; d_mask = ONES; d_chg = '0;
    w_clear = 1'b0; w_valid = 1'b0; w_oready = 1'b0; w_mask = ONES; w_chg = '0;

    // Batch of ramps: lane k = k+1 each beat
    for (int i = 1; i <= 4; i++)
      add(1'b1, 1'b0, 1'b0, 1'b1, ONES, 32'd0, 32'd0, (i == 4), (i != 4), 3'(i), 1'b0,
          64'(i), 64'(2 * i), 64'(32 * i));
    add(1'b0, 1'b0, 1'b1, 1'b0, ONES, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    // Signed lane0: -5, -5, 3, 3
    add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1, 3'd1, 1'b0,
        64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1, 3'd2, 1'b0,
        64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 64'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'd3, 32'd0, 1'b0, 1'b1, 3'd3, 1'b0,
        64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'd3, 32'd0, 1'b1, 1'b0, 3'd4, 1'b0,
        64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, ONES, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    // Only lane0 enabled, all lanes driven with 7
    for (int i = 1; i <= 4; i++)
      add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'd7, 32'd7, (i == 4), (i != 4), 3'(i), 1'b0,
          64'(7 * i), 64'd0, 64'd0);
    // FULL with consumer stalled and new data offered: nothing changes
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'd100, 32'd100, 1'b1, 1'b0, 3'd4, 1'b0,
          64'd28, 64'd0, 64'd0);
    add(1'b1, 1'b0, 1'b1, 1'b0, ONES, 32'd100, 32'd100, 1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    for (int i = 1; i <= 4; i++)
      add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'd1, 32'd0, (i == 4), (i != 4), 3'(i), 1'b0,
          64'(i), 64'd0, 64'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, ONES, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    // Clear mid-batch with a simultaneous valid beat
    add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'd9, 32'd0, 1'b0, 1'b1, 3'd1, 1'b0, 64'd9, 64'd0, 64'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'd9, 32'd0, 1'b0, 1'b1, 3'd2, 1'b0, 64'd18, 64'd0, 64'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, ONES, 32'd9, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    for (int i = 1; i <= 4; i++)
      add(1'b1, 1'b0, 1'b0, 1'b0, ONES, 32'd1, 32'd0, (i == 4), (i != 4), 3'(i), 1'b0,
          64'(i), 64'd0, 64'd0);
    // Clear while FULL
    add(1'b0, 1'b1, 1'b0, 1'b0, ONES, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0);

    // Reset state
    #1;
    chk("in_ready_in_reset", 64'(d_ready), 64'd0);
    chk("out_valid_in_reset", 64'(d_ov), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(d_ready), 64'd1);
    chk("reset_count", 64'(d_cnt), 64'd0);
    chk("reset_overflow", 64'(d_ovf), 64'd0);
    chk("reset_lane0", d_bp[0], 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      d_valid  = tbl[i].valid;
      d_clear  = tbl[i].clear;
      d_oready = tbl[i].oready;
      d_mask   = tbl[i].mask;
      for (int k = 0; k < 32; k++)
        d_chg[k] = tbl[i].ramp ? 32'(k + 1) : ((k == 0) ? tbl[i].a : tbl[i].b);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(d_ov), 64'(tbl[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 64'(d_ready), 64'(tbl[i].e_ir));
      chk($sformatf("v%0d_count", i), 64'(d_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_overflow", i), 64'(d_ovf), 64'(tbl[i].e_ovf));
      chk($sformatf("v%0d_lane0", i), d_bp[0], tbl[i].e_l0);
      chk($sformatf("v%0d_lane1", i), d_bp[1], tbl[i].e_l1);
      chk($sformatf("v%0d_lane31", i), d_bp[31], tbl[i].e_l31);
    end

    // Async reset while FULL, asserted between clock edges
    @(negedge clk);
    d_valid = 1'b1; d_clear = 1'b0; d_oready = 1'b0; d_mask = ONES;
    for (int k = 0; k < 32; k++) d_chg[k] = (k == 0) ? 32'd5 : 32'd0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_full", 64'(d_ov), 64'd1);
    chk("pre_reset_lane0", d_bp[0], 64'd20);
    d_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(d_ov), 64'd0);
    chk("async_rst_count", 64'(d_cnt), 64'd0);
    chk("async_rst_in_ready", 64'(d_ready), 64'd0);
    chk("async_rst_lane0", d_bp[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(d_ready), 64'd1);

    // Narrow accumulator: positive saturation
    for (int i = 1; i <= 8; i++) begin
      wstep(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      if (i == 4) begin
        chk("w_beat4_lane0", 64'(w_bp[0]), 64'h1_FFFF_FFFC);
        chk("w_beat4_ovf", 64'(w_ovf), 64'd0);
      end
      if (i == 5) begin
        chk("w_beat5_lane0", 64'(w_bp[0]), 64'h1_FFFF_FFFF);
        chk("w_beat5_ovf", 64'(w_ovf), 64'd1);
      end
    end
    chk("w_sat_out_valid", 64'(w_ov), 64'd1);
    chk("w_sat_count", 64'(w_cnt), 64'd8);
    chk("w_sat_lane31", 64'(w_bp[31]), 64'h1_FFFF_FFFF);
    chk("w_sat_ovf", 64'(w_ovf), 64'd1);
    wstep(1'b0, 1'b1, 32'd0, 32'd0);
    chk("w_handoff_ovf", 64'(w_ovf), 64'd0);
    chk("w_handoff_lane0", 64'(w_bp[0]), 64'd0);
    chk("w_handoff_ready", 64'(w_ready), 64'd1);
    for (int i = 1; i <= 8; i++) wstep(1'b1, 1'b0, 32'd0, 32'd0);
    chk("w_zero_out_valid", 64'(w_ov), 64'd1);
    chk("w_zero_lane0", 64'(w_bp[0]), 64'd0);
    chk("w_zero_ovf", 64'(w_ovf), 64'd0);
    wstep(1'b0, 1'b1, 32'd0, 32'd0);
    // Negative saturation on lane0 only
    for (int i = 1; i <= 8; i++) wstep(1'b1, 1'b0, 32'h8000_0000, 32'd0);
    chk("w_neg_lane0", 64'(w_bp[0]), 64'h2_0000_0000);
    chk("w_neg_lane1", 64'(w_bp[1]), 64'd0);
    chk("w_neg_ovf", 64'(w_ovf), 64'd1);
    wstep(1'b0, 1'b0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
